// File: rtl/pipelined_wallace_mult.sv
// Pipelined chunked multiplier with valid/ready flow control.
// Operands are split into CHUNK-bit slices. S1 registers every slice-pair
// product at its place value, and a registered pairwise adder tree reduces
// them one level per stage. The final stage applies the sign and holds the
// result under backpressure.
// Optional feature: define MULT_TAG_EN to carry a TAG_W-bit tag alongside
// each transaction (in_tag -> out_tag).
`timescale 1ns/1ps
module pipelined_wallace_mult #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
`ifdef MULT_TAG_EN
    , parameter int TAG_W = 4
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 in_signed,
`ifdef MULT_TAG_EN
    input  logic [TAG_W-1:0]     in_tag,
    output logic [TAG_W-1:0]     out_tag,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_p,
    output logic                 busy
);
    localparam int N      = WIDTH / CHUNK;
    localparam int NT     = N * N;
    localparam int LEVELS = $clog2(NT);
    // S0, S1, LEVELS tree stages, output stage
    localparam int STAGES = 3 + LEVELS;
    localparam int OUT    = STAGES - 1;

    logic [STAGES-1:0]  v_q;
    logic [STAGES-1:0]  ld;
    logic [OUT-1:0]     neg_q;
    logic [WIDTH-1:0]   a_d, b_d, a_q, b_q;
    logic               neg_d;
    logic [2*WIDTH-1:0] out_p_d, out_p_q;

    // A stage may load when it is empty or its content moves on this cycle.
    // Walks back from the output so a stall only reaches stages that are full.
    always_comb begin
        logic nxt;
        nxt     = !v_q[OUT] || out_ready;
        ld      = '0;
        ld[OUT] = nxt;
        for (int k = OUT - 1; k >= 0; k--) begin
            nxt   = !v_q[k] || nxt;
            ld[k] = nxt;
        end
    end

    assign in_ready  = ld[0];
    assign out_valid = v_q[OUT];
    assign busy      = |v_q;
    assign out_p     = out_p_q;

    // Valid bits advance with the load enables; reset discards everything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
        end else begin
            if (ld[0]) v_q[0] <= in_valid;
            for (int k = 1; k < STAGES; k++)
                if (ld[k]) v_q[k] <= v_q[k-1];
        end
    end

    // Signed mode works on magnitudes; -2^(W-1) maps to unsigned 2^(W-1).
    always_comb begin
        a_d   = in_a;
        b_d   = in_b;
        neg_d = 1'b0;
        if (in_signed) begin
            a_d   = in_a[WIDTH-1] ? -in_a : in_a;
            b_d   = in_b[WIDTH-1] ? -in_b : in_b;
            neg_d = in_a[WIDTH-1] ^ in_b[WIDTH-1];
        end
    end

    // S0 operand capture.
    always_ff @(posedge clk) begin
        if (ld[0]) begin
            a_q <= a_d;
            b_q <= b_d;
        end
    end

    // Sign flag travels alongside the data through S0..last tree stage.
    always_ff @(posedge clk) begin
        if (ld[0]) neg_q[0] <= neg_d;
        for (int k = 1; k < OUT; k++)
            if (ld[k]) neg_q[k] <= neg_q[k-1];
    end

    // lv[0] is S1 (placed slice products); lv[l] halves the term count of lv[l-1].
    for (genvar l = 0; l <= LEVELS; l++) begin : lv
        localparam int TN = NT >> l;
        logic [2*WIDTH-1:0] t_q [TN];
        if (l == 0) begin : g_pp
            logic [2*WIDTH-1:0] pp [NT];
            // Each CHUNKxCHUNK product zero-extended and shifted to (i+j)*CHUNK.
            always_comb begin
                for (int i = 0; i < N; i++) begin
                    for (int j = 0; j < N; j++) begin
                        pp[i*N+j] = '0;
                        pp[i*N+j][(i+j)*CHUNK +: 2*CHUNK] =
                            {{CHUNK{1'b0}}, a_q[i*CHUNK +: CHUNK]} *
                            {{CHUNK{1'b0}}, b_q[j*CHUNK +: CHUNK]};
                    end
                end
            end
            // S1 register of all partial products.
            always_ff @(posedge clk) begin
                if (ld[1]) t_q <= pp;
            end
        end else begin : g_add
            // One tree level: add adjacent pairs; carry-out past 2*WIDTH cannot occur.
            always_ff @(posedge clk) begin
                if (ld[l+1])
                    for (int j = 0; j < TN; j++)
                        t_q[j] <= lv[l-1].t_q[2*j] + lv[l-1].t_q[2*j+1];
            end
        end
    end

    assign out_p_d = neg_q[OUT-1] ? -lv[LEVELS].t_q[0] : lv[LEVELS].t_q[0];

    // Output register: only loads real data, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        out_p_q <= '0;
        else if (ld[OUT] && v_q[OUT-1]) out_p_q <= out_p_d;
    end

`ifdef MULT_TAG_EN
    logic [OUT-1:0][TAG_W-1:0] tag_q;
    logic [TAG_W-1:0]          out_tag_q;

    // Tag pipeline mirrors the data stages.
    always_ff @(posedge clk) begin
        if (ld[0]) tag_q[0] <= in_tag;
        for (int k = 1; k < OUT; k++)
            if (ld[k]) tag_q[k] <= tag_q[k-1];
    end

    // Output tag register aligned with out_p.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                        out_tag_q <= '0;
        else if (ld[OUT] && v_q[OUT-1]) out_tag_q <= tag_q[OUT-1];
    end

    assign out_tag = out_tag_q;
`endif

endmodule
